// File: rtl/rf_wb_queue.sv
// Writeback queue feeding the register file write port, with optional
// read-port forwarding of pending entries (enabled by RF_WB_QUEUE_FWD_EN).
module rf_wb_queue #(
  parameter int N          = 5,
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [N-1:0]          in_addr,
  input  logic [31:0]           in_data,
  input  logic                  hold,
  output logic                  we3,
  output logic [N-1:0]          wa3,
  output logic [31:0]           wd3,
  input  logic [N-1:0]          ra1,
  input  logic [N-1:0]          ra2,
  output logic                  fwd1_hit,
  output logic                  fwd2_hit,
  output logic [31:0]           fwd1_data,
  output logic [31:0]           fwd2_data,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  empty,
  output logic                  full
);

  localparam int                DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

  logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
  logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic [N-1:0]          addr_mem [DEPTH];
  logic [31:0]           data_mem [DEPTH];
  logic                  push;
  logic                  pop;

  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH_CNT);
  assign in_ready = !full;
  assign count    = count_q;
  assign we3      = !empty && !hold;
  assign wa3      = addr_mem[rd_ptr_q];
  assign wd3      = data_mem[rd_ptr_q];

  // Register 0 requests complete the handshake but are dropped here.
  assign push = in_valid && in_ready && (in_addr != '0);
  assign pop  = we3;

  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + DEPTH_LOG2'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + DEPTH_LOG2'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + (DEPTH_LOG2 + 1)'(1);
      2'b01:   count_d = count_q - (DEPTH_LOG2 + 1)'(1);
      default: count_d = count_q;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // NOTE: entry storage is deliberately not reset; validity comes from the pointers and count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= in_addr;
      data_mem[wr_ptr_q] <= in_data;
    end
  end

`ifdef RF_WB_QUEUE_FWD_EN
  // Walk oldest to newest so the youngest matching entry overwrites earlier hits.
  always_comb begin
    fwd1_hit  = 1'b0;
    fwd2_hit  = 1'b0;
    fwd1_data = '0;
    fwd2_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if ((DEPTH_LOG2 + 1)'(i) < count_q) begin
        if (ra1 != '0 && addr_mem[rd_ptr_q + DEPTH_LOG2'(i)] == ra1) begin
          fwd1_hit  = 1'b1;
          fwd1_data = data_mem[rd_ptr_q + DEPTH_LOG2'(i)];
        end
        if (ra2 != '0 && addr_mem[rd_ptr_q + DEPTH_LOG2'(i)] == ra2) begin
          fwd2_hit  = 1'b1;
          fwd2_data = data_mem[rd_ptr_q + DEPTH_LOG2'(i)];
        end
      end
    end
  end
`else
  logic unused_ra;
  assign unused_ra = ^{ra1, ra2};
  assign fwd1_hit  = 1'b0;
  assign fwd2_hit  = 1'b0;
  assign fwd1_data = '0;
  assign fwd2_data = '0;
`endif

endmodule

// File: tb/tb_rf_wb_queue.sv
// Self-checking bench for rf_wb_queue: directed scenarios plus randomized
// traffic compared against a queue-based reference model.
module tb_rf_wb_queue;

  localparam int N     = 5;
  localparam int DL2   = 2;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [N-1:0]  in_addr;
  logic [31:0]   in_data;
  logic          hold;
  logic          we3;
  logic [N-1:0]  wa3;
  logic [31:0]   wd3;
  logic [N-1:0]  ra1, ra2;
  logic          fwd1_hit, fwd2_hit;
  logic [31:0]   fwd1_data, fwd2_data;
  logic [DL2:0]  count;
  logic          empty, full;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [N-1:0] a;
    logic [31:0]  d;
  } ent_t;
  ent_t mq[$];

  rf_wb_queue #(.N(N), .DEPTH_LOG2(DL2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr), .in_data(in_data),
    .hold(hold), .we3(we3), .wa3(wa3), .wd3(wd3),
    .ra1(ra1), .ra2(ra2),
    .fwd1_hit(fwd1_hit), .fwd2_hit(fwd2_hit), .fwd1_data(fwd1_data), .fwd2_data(fwd2_data),
    .count(count), .empty(empty), .full(full)
  );

  always #5 clk = ~clk;

  // Reference: a FIFO of pending writes; address 0 is never queued.
  task automatic tick();
    bit acc, pp;
    ent_t e;
    acc = in_valid && (mq.size() < DEPTH);
    pp  = (mq.size() != 0) && !hold;
    e.a = in_addr;
    e.d = in_data;
    @(posedge clk);
    #1;
    if (pp) void'(mq.pop_front());
    if (acc && e.a != 0) mq.push_back(e);
  endtask

  function automatic void model_fwd(input logic [N-1:0] ra, output logic hit,
                                    output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
`ifdef RF_WB_QUEUE_FWD_EN
    if (ra != 0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (mq[i].a == ra) begin
          hit = 1'b1;
          d   = mq[i].d;
          break;
        end
      end
    end
`endif
  endfunction

  task automatic test_reset();
    total++; if (count !== 3'd0)      begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1)      begin bad++; $display("FAIL reset_empty got=%b want=1", empty); end
    total++; if (full !== 1'b0)       begin bad++; $display("FAIL reset_full got=%b want=0", full); end
    total++; if (in_ready !== 1'b1)   begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (we3 !== 1'b0)        begin bad++; $display("FAIL reset_we3 got=%b want=0", we3); end
    total++; if ({fwd1_hit, fwd2_hit, fwd1_data, fwd2_data} !== '0)
      begin bad++; $display("FAIL reset_fwd got=%b/%b %h/%h want=0", fwd1_hit, fwd2_hit, fwd1_data, fwd2_data); end
  endtask

  task automatic test_basic_write();
    hold = 0; in_valid = 1; in_addr = 5; in_data = 32'hDEADBEEF;
    tick();
    in_valid = 0;
    #1;
    total++; if (we3 !== 1'b1)          begin bad++; $display("FAIL basic_we3 got=%b want=1", we3); end
    total++; if (wa3 !== 5'd5)          begin bad++; $display("FAIL basic_wa3 got=%0d want=5", wa3); end
    total++; if (wd3 !== 32'hDEADBEEF)  begin bad++; $display("FAIL basic_wd3 got=%h want=deadbeef", wd3); end
    total++; if (count !== 3'd1)        begin bad++; $display("FAIL basic_count got=%0d want=1", count); end
    tick();
    total++; if (we3 !== 1'b0)          begin bad++; $display("FAIL basic_we3_after got=%b want=0", we3); end
    total++; if (empty !== 1'b1)        begin bad++; $display("FAIL basic_empty got=%b want=1", empty); end
  endtask

  task automatic test_fill_drain();
    hold = 1;
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1; in_addr = N'(i); in_data = 32'h11 * i;
      tick();
    end
    in_addr = 9; in_data = 32'h99;
    #1;
    total++; if (full !== 1'b1)     begin bad++; $display("FAIL fill_full got=%b want=1", full); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fill_in_ready got=%b want=0", in_ready); end
    tick();
    in_valid = 0;
    total++; if (count !== 3'd4)    begin bad++; $display("FAIL fill_5th_rejected count got=%0d want=4", count); end
    hold = 0;
    for (int i = 1; i <= 4; i++) begin
      #1;
      total++;
      if (we3 !== 1'b1 || wa3 !== N'(i) || wd3 !== 32'h11 * i) begin
        bad++; $display("FAIL drain_%0d got we3=%b wa3=%0d wd3=%h want 1/%0d/%h", i, we3, wa3, wd3, i, 32'h11 * i);
      end
      tick();
    end
    total++; if (empty !== 1'b1 || we3 !== 1'b0)
      begin bad++; $display("FAIL drain_empty got empty=%b we3=%b want 1/0", empty, we3); end
  endtask

  task automatic test_reg0();
    hold = 0; in_valid = 1; in_addr = 0; in_data = 32'hFFFFFFFF; ra1 = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reg0_ready got=%b want=1", in_ready); end
    tick();
    in_valid = 0;
    #1;
    total++; if (count !== 3'd0 || we3 !== 1'b0)
      begin bad++; $display("FAIL reg0_dropped got count=%0d we3=%b want 0/0", count, we3); end
    total++; if (fwd1_hit !== 1'b0) begin bad++; $display("FAIL reg0_fwd got=%b want=0", fwd1_hit); end
  endtask

  task automatic test_forward();
    logic        eh;
    logic [31:0] ed;
    hold = 1; in_valid = 1; in_addr = 7; in_data = 32'h1;
    tick();
    in_data = 32'h2;
    tick();
    in_valid = 0; ra1 = 7; ra2 = 3;
    #1;
`ifdef RF_WB_QUEUE_FWD_EN
    eh = 1'b1; ed = 32'h2;
`else
    eh = 1'b0; ed = 32'h0;
`endif
    total++; if (fwd1_hit !== eh || fwd1_data !== ed)
      begin bad++; $display("FAIL fwd1 got=%b/%h want=%b/%h", fwd1_hit, fwd1_data, eh, ed); end
    total++; if (fwd2_hit !== 1'b0 || fwd2_data !== 32'h0)
      begin bad++; $display("FAIL fwd2 got=%b/%h want=0/0", fwd2_hit, fwd2_data); end
    hold = 0;
    tick();
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL fwd_drain_empty got=%b want=1", empty); end
  endtask

  task automatic test_wrap();
    hold = 1; in_valid = 1;
    in_addr = 1; in_data = 32'hA0; tick();
    in_addr = 2; in_data = 32'hA1; tick();
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      in_addr = N'(i % 31 + 1); in_data = i;
      #1;
      total++; if (count !== 3'd2) begin bad++; $display("FAIL wrap_count_%0d got=%0d want=2", i, count); end
      total++;
      if (we3 !== 1'b1 || wa3 !== mq[0].a || wd3 !== mq[0].d) begin
        bad++; $display("FAIL wrap_head_%0d got=%0d/%h want=%0d/%h", i, wa3, wd3, mq[0].a, mq[0].d);
      end
      tick();
    end
    in_valid = 0;
    tick();
    tick();
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL wrap_drain got empty=%b want=1", empty); end
  endtask

  task automatic test_reset_mid();
    hold = 1; in_valid = 1;
    for (int i = 0; i < 3; i++) begin
      in_addr = N'(10 + i); in_data = 32'hC0 + i; tick();
    end
    in_valid = 0; hold = 0; ra1 = 10; ra2 = 12;
    #1;
    total++; if (we3 !== 1'b1 || count !== 3'd3)
      begin bad++; $display("FAIL pre_reset got we3=%b count=%0d want 1/3", we3, count); end
    rst_n = 0;
    #1;
    mq.delete();
    total++; if (we3 !== 1'b0 || empty !== 1'b1 || count !== 3'd0)
      begin bad++; $display("FAIL mid_reset got we3=%b empty=%b count=%0d want 0/1/0", we3, empty, count); end
    total++; if (fwd1_hit !== 1'b0 || fwd2_hit !== 1'b0)
      begin bad++; $display("FAIL mid_reset_fwd got=%b/%b want=0/0", fwd1_hit, fwd2_hit); end
    #2 rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (we3 !== 1'b0) begin bad++; $display("FAIL stale_write_%0d got we3=%b wa3=%0d want 0", i, we3, wa3); end
    end
  endtask

  task automatic test_random();
    logic        eh1, eh2;
    logic [31:0] ed1, ed2;
    for (int c = 0; c < 400; c++) begin
      in_valid = ($urandom_range(0, 3) != 0);
      in_addr  = N'($urandom_range(0, 7));
      in_data  = $urandom;
      hold     = ($urandom_range(0, 3) == 0);
      ra1      = N'($urandom_range(0, 7));
      ra2      = N'($urandom_range(0, 7));
      #1;
      model_fwd(ra1, eh1, ed1);
      model_fwd(ra2, eh2, ed2);
      total++; if (count !== 3'(mq.size()))
        begin bad++; $display("FAIL rnd_count c=%0d got=%0d want=%0d", c, count, mq.size()); end
      total++; if (in_ready !== (mq.size() < DEPTH) || full !== (mq.size() == DEPTH) || empty !== (mq.size() == 0))
        begin bad++; $display("FAIL rnd_flags c=%0d got rdy=%b full=%b empty=%b size=%0d", c, in_ready, full, empty, mq.size()); end
      total++; if (we3 !== (mq.size() != 0 && !hold))
        begin bad++; $display("FAIL rnd_we3 c=%0d got=%b want=%b", c, we3, (mq.size() != 0 && !hold)); end
      if (mq.size() != 0) begin
        total++; if (wa3 !== mq[0].a || wd3 !== mq[0].d)
          begin bad++; $display("FAIL rnd_head c=%0d got=%0d/%h want=%0d/%h", c, wa3, wd3, mq[0].a, mq[0].d); end
      end
      total++; if (fwd1_hit !== eh1 || fwd1_data !== ed1)
        begin bad++; $display("FAIL rnd_fwd1 c=%0d ra=%0d got=%b/%h want=%b/%h", c, ra1, fwd1_hit, fwd1_data, eh1, ed1); end
      total++; if (fwd2_hit !== eh2 || fwd2_data !== ed2)
        begin bad++; $display("FAIL rnd_fwd2 c=%0d ra=%0d got=%b/%h want=%b/%h", c, ra2, fwd2_hit, fwd2_data, eh2, ed2); end
      tick();
    end
    in_valid = 0; hold = 0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_addr = 0; in_data = 0; hold = 0; ra1 = 0; ra2 = 0;
    #12;
    test_reset();
    #1 rst_n = 1;
    @(posedge clk); #1;
    test_basic_write();
    test_fill_drain();
    test_reg0();
    test_forward();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rf_wb_queue.md
# rf_wb_queue

Writeback buffer that sits directly upstream of the register file's write port. It accepts register-write results from the writeback stage over a valid/ready handshake and queues them in a small FIFO. It drains one entry per cycle onto the register file's `we3`/`wa3`/`wd3` port. Optionally, it forwards pending data to the register file's two read ports so readers never see a stale value.

## Interface
- `N`, default 5: register address width; must match the register file's `N`.
- `DEPTH_LOG2`, default 2: log2 of queue depth (default 4 entries).
- `clk` in 1: single clock; all state updates on rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: upstream write request valid.
- `in_ready` out 1: queue can accept; `!full`.
- `in_addr` in N: destination register.
- `in_data` in 32: write data.
- `hold` in 1: when 1, suppress draining (debug/stall).
- `we3` out 1: register file write enable.
- `wa3` out N: register file write address (head entry).
- `wd3` out 32: register file write data (head entry).
- `ra1`, `ra2` in N: copies of the register file read addresses.
- `fwd1_hit`, `fwd2_hit` out 1: a pending entry matches `ra1`/`ra2`.
- `fwd1_data`, `fwd2_data` out 32: newest matching pending data.
- `count` out DEPTH_LOG2+1: occupied entries, 0..2**DEPTH_LOG2.
- `empty`, `full` out 1: `count==0`, `count==2**DEPTH_LOG2`.

## Operation
- Circular FIFO with read pointer, write pointer, and count. Pointers are DEPTH_LOG2 bits and wrap modulo depth.
- Accept: a transfer occurs when `in_valid && in_ready` at a rising edge.
  - If `in_addr != 0`, `{in_addr,in_data}` is written at the write pointer and the pointer advances.
  - If `in_addr == 0`, the transfer completes (handshake consumed) but nothing is enqueued; register 0 is never written.
- `in_ready = !full`, purely from state. There is no pass-through when full, even if a pop occurs in the same cycle.
- Drain:
  - `we3 = !empty && !hold`.
  - `wa3`/`wd3` always present the head entry; they are don't-care when `empty`.
  - When `we3` is 1 at a rising edge, the head is popped and the read pointer advances.
- Simultaneous push and pop: both pointers advance and `count` is unchanged. Order is strict FIFO.
- Forwarding (see Configuration):
  - For each read port, all valid entries are searched combinationally, including the head being written this cycle. The newest match wins.
  - `ra==0` never hits.
  - The current-cycle `in_*` request is not forwarded.
  - `fwdX_data` is 0 when `fwdX_hit` is 0.
- Reset (`rst_n` low, asynchronous, also mid-operation):
  - Pointers and `count` are cleared and all pending entries are discarded.
  - Outputs: `count=0`, `empty=1`, `full=0`, `in_ready=1`, `we3=0`, `fwd1_hit=fwd2_hit=0`, `fwd1_data=fwd2_data=0`.
  - Entry storage is not reset.

## Timing
- Accept at edge k into an empty queue gives `we3=1` during cycle k..k+1. The register file captures the write at edge k+1.
- Sustained throughput is 1 write/cycle; `count` stays constant under steady push and pop.
- `we3`, `wa3`, `wd3`, `in_ready`, `empty`, `full`, and `count` depend only on state and `hold`, so they are glitch-free after the edge.
- `fwd*` outputs are combinational from `ra1`/`ra2` and state, valid in the same cycle.
- `hold` takes effect in the same cycle: `we3` drops immediately and no pop occurs at the next edge.

## Configuration
- `RF_WB_QUEUE_FWD_EN`:
  - When defined, the forwarding search logic is compiled in as described.
  - When undefined, `fwd1_hit`, `fwd2_hit`, `fwd1_data`, and `fwd2_data` are tied to 0, and `ra1`/`ra2` are unused. Queue behaviour is otherwise identical.

## Test plan
- Basic write: from reset, push (5, 0xDEADBEEF) with `hold=0`.
  - Next cycle: `we3=1`, `wa3=5`, `wd3=0xDEADBEEF`, `count=1`.
  - Following cycle: `we3=0`, `empty=1`.
- Fill and drain: with `hold=1`, push (1,0x11), (2,0x22), (3,0x33), (4,0x44).
  - `full=1` and `in_ready=0`; a 5th request is not accepted.
  - Release `hold`: four consecutive `we3` cycles in order 1→4, then `empty=1`.
- Register 0: push (0, 0xFFFFFFFF).
  - Handshake completes, `count` stays 0, `we3` stays 0, and no forward hit occurs for `ra1=0`.
- Forwarding (`RF_WB_QUEUE_FWD_EN` defined): with `hold=1`, push (7,0x1) then (7,0x2); set `ra1=7`, `ra2=3`.
  - `fwd1_hit=1`, `fwd1_data=0x2`, `fwd2_hit=0`.
  - Without the macro: all `fwd*` outputs are 0.
- Wrap and concurrency: hold `count` at 2 while pushing and popping every cycle for 10 cycles with data 0..9.
  - `count` stays 2.
  - Writes appear in push order across pointer wrap.
- Reset mid-operation: with 3 entries queued, pulse `rst_n` low between edges.
  - Immediately `we3=0`, `empty=1`, `count=0`.
  - After release, no stale entry is ever written.
